// File: rtl/am_demod.sv
// AM envelope demodulator: per-window peak-to-peak detection scaled to a distance.
// Optional macro AM_DEMOD_AVG_EN averages 2**LOG2_AVG windows per emitted result.
module am_demod #(
  parameter int WIDTH         = 13,
  parameter int SINE_WIDTH    = 7,
  parameter int LOG2_MAX_DIST = 11,
  parameter int WINDOW        = 100,
  parameter int LOG2_AVG      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SINE_WIDTH-1:0] sine_am_in,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      distance_out,
  output logic                  out_valid,
  output logic                  saturated,
  output logic                  overrun
);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EST_W = LOG2_MAX_DIST + 1;
  localparam int SHIFT = LOG2_MAX_DIST - SINE_WIDTH;

  if (SHIFT < 0 || LOG2_AVG < 0 || WIDTH < EST_W) begin : g_param_check
    $error("am_demod: invalid parameter combination");
  end

  logic [CNT_W-1:0]      sample_cnt;
  logic [SINE_WIDTH-1:0] max_val, min_val, p2p;
  logic                  win_done, p2p_vld;
  logic [EST_W-1:0]      est;
  logic                  est_sat;
  logic                  res_vld;
  logic [WIDTH-1:0]      res_data;
  logic                  res_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      max_val    <= '0;
      min_val    <= '0;
      win_done   <= 1'b0;
    end else begin
      win_done <= enable && (sample_cnt == CNT_W'(WINDOW - 1));
      if (enable) begin
        if (sample_cnt == CNT_W'(WINDOW - 1)) sample_cnt <= '0;
        else                                  sample_cnt <= sample_cnt + 1'b1;
        if (sample_cnt == '0) begin
          max_val <= sine_am_in;
          min_val <= sine_am_in;
        end else begin
          if (sine_am_in > max_val) max_val <= sine_am_in;
          if (sine_am_in < min_val) min_val <= sine_am_in;
        end
      end
    end
  end

  // p2p reads the extremes registered on the previous edge, so a new window
  // reloading max/min on this same edge does not disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p2p     <= '0;
      p2p_vld <= 1'b0;
    end else begin
      p2p_vld <= win_done;
      if (win_done) p2p <= max_val - min_val;
    end
  end

  always_comb begin
    est_sat = (p2p == '1);
    est     = EST_W'(p2p) << SHIFT;
    if (est_sat) est = EST_W'(1) << LOG2_MAX_DIST;
  end

`ifdef AM_DEMOD_AVG_EN
  localparam int ACC_W = EST_W + LOG2_AVG;
  localparam int GRP_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  logic [ACC_W-1:0] acc, grp_sum;
  logic [GRP_W-1:0] grp_cnt;
  logic             acc_sat, grp_sat, grp_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      grp_cnt <= '0;
      grp_sum <= '0;
      grp_sat <= 1'b0;
      grp_vld <= 1'b0;
    end else begin
      grp_vld <= 1'b0;
      if (p2p_vld) begin
        if (grp_cnt == GRP_W'((1 << LOG2_AVG) - 1)) begin
          grp_sum <= acc + ACC_W'(est);
          grp_sat <= acc_sat | est_sat;
          grp_vld <= 1'b1;
          acc     <= '0;
          acc_sat <= 1'b0;
          grp_cnt <= '0;
        end else begin
          acc     <= acc + ACC_W'(est);
          acc_sat <= acc_sat | est_sat;
          grp_cnt <= grp_cnt + 1'b1;
        end
      end
    end
  end

  assign res_vld  = grp_vld;
  assign res_data = WIDTH'(grp_sum >> LOG2_AVG);
  assign res_sat  = grp_sat;
`else
  assign res_vld  = p2p_vld;
  assign res_data = WIDTH'(est);
  assign res_sat  = est_sat;
`endif

  // A result landing on an accepting edge keeps out_valid high with fresh data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      distance_out <= '0;
      out_valid    <= 1'b0;
      saturated    <= 1'b0;
      overrun      <= 1'b0;
    end else if (res_vld) begin
      distance_out <= res_data;
      saturated    <= res_sat;
      out_valid    <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_am_demod.sv
// Self-checking bench for am_demod: directed windows with literal expectations
// plus randomized traffic against a behavioural window/handshake model.
module tb_am_demod;
  localparam int WIDTH         = 13;
  localparam int SINE_WIDTH    = 7;
  localparam int LOG2_MAX_DIST = 11;
  localparam int WINDOW        = 100;
  localparam int LOG2_AVG      = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b0;
  logic [SINE_WIDTH-1:0] sine_am_in = '0;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      distance_out;
  logic                  out_valid, saturated, overrun;

  am_demod #(
    .WIDTH(WIDTH), .SINE_WIDTH(SINE_WIDTH), .LOG2_MAX_DIST(LOG2_MAX_DIST),
    .WINDOW(WINDOW), .LOG2_AVG(LOG2_AVG)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sine_am_in(sine_am_in),
    .out_ready(out_ready), .distance_out(distance_out), .out_valid(out_valid),
    .saturated(saturated), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: output view, current window samples, one pending result.
  bit m_valid, m_sat, m_ovr;
  int m_data;
  int win[$];
  bit p_act;
  int p_due, p_data;
  bit p_sat;
  int cyc = 0;
  int g_n, g_sum;
  bit g_sat;

  task automatic check(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sat = 0; m_ovr = 0; m_data = 0;
    win.delete();
    p_act = 0; g_n = 0; g_sum = 0; g_sat = 0;
  endtask

  task automatic model_edge(bit en, int s, bit rdy);
    int mx, mn, p2p, est;
    bit sat;
    cyc++;
    if (p_act && p_due == cyc) begin
      if (m_valid && !rdy) m_ovr = 1;
      m_valid = 1; m_data = p_data; m_sat = p_sat; p_act = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (en) begin
      win.push_back(s);
      if (win.size() == WINDOW) begin
        mx = 0; mn = (1 << SINE_WIDTH) - 1;
        foreach (win[i]) begin
          if (win[i] > mx) mx = win[i];
          if (win[i] < mn) mn = win[i];
        end
        win.delete();
        p2p = mx - mn;
        sat = (p2p == (1 << SINE_WIDTH) - 1);
        est = sat ? (1 << LOG2_MAX_DIST) : p2p * (1 << (LOG2_MAX_DIST - SINE_WIDTH));
`ifdef AM_DEMOD_AVG_EN
        g_sum += est; g_sat |= sat; g_n++;
        if (g_n == (1 << LOG2_AVG)) begin
          p_act = 1; p_due = cyc + 3; p_data = g_sum / (1 << LOG2_AVG); p_sat = g_sat;
          g_n = 0; g_sum = 0; g_sat = 0;
        end
`else
        p_act = 1; p_due = cyc + 2; p_data = est; p_sat = sat;
`endif
      end
    end
  endtask

  task automatic compare_model();
    check("out_valid", 32'(out_valid), int'(m_valid));
    check("overrun", 32'(overrun), int'(m_ovr));
    if (m_valid) begin
      check("distance_out", 32'(distance_out), m_data);
      check("saturated", 32'(saturated), int'(m_sat));
    end
  endtask

  task automatic step(bit en, int s, bit rdy);
    enable = en; sine_am_in = SINE_WIDTH'(s); out_ready = rdy;
    @(posedge clk);
    model_edge(en, s, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_model();
  endtask

  // Full window alternating a/b, then one idle edge (result not yet visible).
  task automatic dir_window(int a, int b);
    for (int i = 0; i < WINDOW; i++) step(1'b1, (i % 2 == 0) ? a : b, 1'b0);
    step(1'b0, 0, 1'b0);
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_dist", 32'(distance_out), 0);
    check("rst_sat", 32'(saturated), 0);
    check("rst_overrun", 32'(overrun), 0);

`ifdef AM_DEMOD_AVG_EN
    dir_window(0, 10); step(1'b0, 0, 1'b0);
    check("avg_w1_no_result", 32'(out_valid), 0);
    dir_window(0, 20);
    dir_window(0, 30);
    dir_window(0, 40);
    step(1'b0, 0, 1'b0);
    check("avg_gap_valid", 32'(out_valid), 0);
    step(1'b0, 0, 1'b0);
    check("avg_valid", 32'(out_valid), 1);
    check("avg_dist", 32'(distance_out), 400);
    check("avg_sat", 32'(saturated), 0);
    step(1'b0, 0, 1'b1);
`else
    dir_window(64, 64);
    check("const_gap_valid", 32'(out_valid), 0);
    step(1'b0, 0, 1'b0);
    check("const_valid", 32'(out_valid), 1);
    check("const_dist", 32'(distance_out), 0);
    check("const_sat", 32'(saturated), 0);
    step(1'b0, 0, 1'b0);
    check("hold_dist", 32'(distance_out), 0);
    step(1'b0, 0, 1'b1);
    check("accept_clears", 32'(out_valid), 0);

    dir_window(0, 80); step(1'b0, 0, 1'b0);
    check("a80_valid", 32'(out_valid), 1);
    check("a80_dist", 32'(distance_out), 1280);
    step(1'b0, 0, 1'b1);

    dir_window(0, 127); step(1'b0, 0, 1'b0);
    check("full_dist", 32'(distance_out), 2048);
    check("full_sat", 32'(saturated), 1);
    step(1'b0, 0, 1'b1);

    dir_window(0, 10); step(1'b0, 0, 1'b0);
    check("p10_dist", 32'(distance_out), 160);
    check("p10_overrun", 32'(overrun), 0);
    dir_window(0, 20); step(1'b0, 0, 1'b0);
    check("ovr_dist", 32'(distance_out), 320);
    check("ovr_flag", 32'(overrun), 1);
    step(1'b0, 0, 1'b1);
    check("ovr_accepted", 32'(out_valid), 0);
    step(1'b0, 0, 1'b0);
    check("ovr_sticky", 32'(overrun), 1);

    for (int i = 0; i < 50; i++) step(1'b1, (i % 2 == 0) ? 0 : 127, 1'b0);
    do_reset();
    check("mid_rst_overrun", 32'(overrun), 0);
    dir_window(0, 40);
    check("mid_rst_gap", 32'(out_valid), 0);
    step(1'b0, 0, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 1);
    check("mid_rst_dist", 32'(distance_out), 640);
    check("mid_rst_no_ovr", 32'(overrun), 0);
    step(1'b0, 0, 1'b1);
`endif

    do_reset();
    for (int n = 0; n < 6000; n++) begin
      int s;
      if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 0) ? 0 : 127;
      else                           s = int'($urandom_range(0, 127));
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 1) == 1);
      if (n == 3137) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/am_demod.md
AM_DEMOD -- requirements
Module: am_demod

Interface
REQ-001 SHALL have parameter WIDTH, default 13, bit width of distance_out.
REQ-002 SHALL have parameter SINE_WIDTH, default 7, bit width of the AM sample input.
REQ-003 SHALL have parameter LOG2_MAX_DIST, default 11; MAX_DIST = 2**LOG2_MAX_DIST.
REQ-004 SHALL have parameter WINDOW, default 100, enabled samples per carrier window (500 kHz carrier at 50 MHz).
REQ-005 SHALL have parameter LOG2_AVG, default 2, log2 of windows averaged per result.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port enable, input, 1, sample strobe; state advances only when high.
REQ-009 SHALL have port sine_am_in, input, SINE_WIDTH, unsigned AM carrier sample.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port distance_out, output, WIDTH, recovered distance.
REQ-012 SHALL have port out_valid, output, 1, distance_out holds an unaccepted result.
REQ-013 SHALL have port saturated, output, 1, current result came from a full-scale window.
REQ-014 SHALL have port overrun, output, 1, sticky flag: an unaccepted result was overwritten.

Function
REQ-015 SHALL count enabled samples 0..WINDOW-1 and wrap to 0 after WINDOW-1.
REQ-016 SHALL load max=min=sample at count 0, then update max/min on each later enabled sample; the sample at count WINDOW-1 is included.
REQ-017 SHALL register p2p = max-min (SINE_WIDTH bits, unsigned) on the edge after the window's last sample.
REQ-018 SHALL scale est = p2p << (LOG2_MAX_DIST-SINE_WIDTH), zero-extended to WIDTH.
REQ-019 SHALL, when p2p == 2**SINE_WIDTH-1, force est = MAX_DIST and mark the window saturated.
REQ-020 SHALL present a window result with out_valid high on the second rising edge after the edge sampling the window's last sample.
REQ-021 SHALL hold distance_out and saturated stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1 unless a new result lands on that edge.
REQ-023 SHALL, on a new result while out_valid=1 and out_ready=0, overwrite data and set overrun.
REQ-024 SHALL, on a new result on the same edge as acceptance, keep out_valid=1 with new data and leave overrun unchanged.
REQ-025 SHALL run the handshake (REQ-021..024) regardless of enable; enable=0 freezes only the window counter and max/min.

Reset
REQ-026 SHALL, while reset=1, asynchronously clear window counter, max, min, p2p, accumulator, and window count.
REQ-027 SHALL reset outputs to distance_out=0, out_valid=0, saturated=0, overrun=0.
REQ-028 SHALL discard any partial window on reset; the first enabled sample after release is count 0.

Configuration
REQ-029 SHALL, with macro AM_DEMOD_AVG_EN defined, sum est over 2**LOG2_AVG windows (LOG2_MAX_DIST+1+LOG2_AVG-bit accumulator) and emit sum >> LOG2_AVG once per group, saturated = OR of the group's window flags, with one extra cycle of latency over REQ-020.
REQ-030 SHALL, without AM_DEMOD_AVG_EN, emit every window's est directly per REQ-020 with no accumulator logic.

Verification
REQ-031 SHALL cover: constant 64 for 100 samples, no AVG -> distance_out=0, saturated=0, out_valid high 2 edges after last sample.
REQ-032 SHALL cover: alternating 0/80 for 100 samples, no AVG -> distance_out=1280.
REQ-033 SHALL cover: alternating 0/127 window -> distance_out=2048, saturated=1.
REQ-034 SHALL cover: out_ready=0 across two windows with p2p 10 then 20 -> overrun=1, distance_out=320; overrun stays 1 after acceptance until reset.
REQ-035 SHALL cover: AM_DEMOD_AVG_EN, four windows with p2p 10,20,30,40 -> one result distance_out=400.
REQ-036 SHALL cover: reset pulse at sample 50 of a window, then 100 samples alternating 0/40 -> single result 640, no overrun.
